// File: rtl/imsic_msi_ingress_if.sv
// MSI channel bundle: per-channel valid/info from the sources, per-channel ready back.
interface imsic_msi_ingress_if #(
    parameter int unsigned NR_CH = 2,
    parameter int unsigned MIW   = 13
);
    logic [NR_CH-1:0]     i_msi_vld;
    logic [NR_CH*MIW-1:0] i_msi_info;
    logic [NR_CH-1:0]     o_msi_rdy;

    modport master (output i_msi_vld, output i_msi_info, input o_msi_rdy);
    modport slave  (input i_msi_vld, input i_msi_info, output o_msi_rdy);
endinterface

// File: rtl/imsic_msi_ingress.sv
// IMSIC MSI ingress: round-robin channel arbitration, hart/file/id filtering, a small
// ingress FIFO drained one entry per cycle, and the merged eip register update
// (software write, then claim clear, then MSI set).
module imsic_msi_ingress #(
    parameter int unsigned NR_INTP_FILES  = 7,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned NR_SRC         = 256,
    parameter int unsigned NR_HARTS       = 4,
    parameter int unsigned NR_HARTS_WIDTH = 2,
    parameter int unsigned NR_CH          = 2,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned SW     = $clog2(NR_SRC),
    localparam int unsigned FW     = $clog2(NR_INTP_FILES),
    localparam int unsigned NR_REG = (NR_SRC + XLEN - 1) / XLEN,
    localparam int unsigned MIW    = NR_HARTS_WIDTH + FW + SW,
    localparam int unsigned NR_EIP = NR_INTP_FILES * NR_REG,
    localparam int unsigned AW     = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NR_HARTS_WIDTH-1:0] hart_id,
    imsic_msi_ingress_if.slave        msi,
    input  logic                      i_claim_vld,
    input  logic [FW-1:0]             i_claim_file,
    input  logic [SW-1:0]             i_claim_id,
    input  logic [NR_EIP-1:0]         i_sw_wr,
    input  logic [NR_EIP*XLEN-1:0]    i_sw_data,
    output logic [NR_EIP*XLEN-1:0]    o_eip,
    output logic [AW:0]               o_fifo_cnt,
    output logic [15:0]               o_drop_cnt,
    output logic                      o_busy
);
    localparam int unsigned CHW = (NR_CH > 1) ? $clog2(NR_CH) : 1;
    localparam int unsigned XW  = $clog2(XLEN);
    localparam int unsigned EW  = FW + SW;

    logic [NR_HARTS_WIDTH-1:0] hart_self;
    logic [CHW-1:0]            rr_q, rr_d, gnt;
    logic [AW:0]               cnt_q, cnt_d;
    logic [AW-1:0]             wptr_q, rptr_q;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [15:0]               drop_q;
    logic [XLEN-1:0]           eip_q [NR_EIP];
    logic [XLEN-1:0]           eip_d [NR_EIP];

    logic                      found, full, accept, legal, push, pop, claim_ok;
    logic [MIW-1:0]            sel_info;
    logic [NR_HARTS_WIDTH-1:0] m_hart;
    logic [FW-1:0]             m_file, pop_file;
    logic [SW-1:0]             m_id, pop_id;
    logic [31:0]               claim_reg, pop_reg;
    logic [XW-1:0]             claim_bit, pop_bit;

    // A single-hart group has no hart field worth matching against.
    assign hart_self = (NR_HARTS == 1) ? '0 : hart_id;

    // Round-robin search for the first valid channel starting at rr_q.
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        sel_info = '0;
        for (int k = 0; k < NR_CH; k++) begin
            if (!found && msi.i_msi_vld[(int'(rr_q) + k) % NR_CH]) begin
                found    = 1'b1;
                gnt      = CHW'((int'(rr_q) + k) % NR_CH);
                sel_info = msi.i_msi_info[((int'(rr_q) + k) % NR_CH) * MIW +: MIW];
            end
        end
    end

    // Full FIFO blocks everything, even while popping: there is no bypass path.
    assign full          = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign accept        = found && !full && rstn;
    assign msi.o_msi_rdy = accept ? (NR_CH'(1) << gnt) : '0;

    assign {m_hart, m_file, m_id} = sel_info;
    assign legal = (m_hart == hart_self) && (32'(m_file) < NR_INTP_FILES) &&
                   (m_id != '0) && (32'(m_id) < NR_SRC);
    assign push  = accept && legal;
    assign pop   = (cnt_q != '0);

    assign {pop_file, pop_id} = mem_q[rptr_q];
    assign pop_reg   = 32'(pop_file) * NR_REG + 32'(pop_id) / XLEN;
    assign pop_bit   = XW'(32'(pop_id) % XLEN);

    assign claim_ok  = i_claim_vld && (32'(i_claim_file) < NR_INTP_FILES) &&
                       (i_claim_id != '0) && (32'(i_claim_id) < NR_SRC);
    assign claim_reg = 32'(i_claim_file) * NR_REG + 32'(i_claim_id) / XLEN;
    assign claim_bit = XW'(32'(i_claim_id) % XLEN);

    // Next RR pointer and FIFO occupancy.
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (32'(gnt) == NR_CH - 1) ? '0 : gnt + CHW'(1);
        end
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    // eip merge: software write first, then claim clear, then MSI set (set wins).
    always_comb begin
        for (int r = 0; r < NR_EIP; r++) begin
            eip_d[r] = i_sw_wr[r] ? i_sw_data[r*XLEN +: XLEN] : eip_q[r];
            if (claim_ok && claim_reg == 32'(r)) begin
                eip_d[r] = eip_d[r] & ~(XLEN'(1) << claim_bit);
            end
            if (pop && pop_reg == 32'(r)) begin
                eip_d[r] = eip_d[r] | (XLEN'(1) << pop_bit);
            end
        end
    end

    // Arbiter, FIFO and drop counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q   <= '0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            drop_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[wptr_q] <= {m_file, m_id};
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (accept && !legal && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Pending-bit registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NR_EIP; r++) begin
                eip_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NR_EIP; r++) begin
                eip_q[r] <= eip_d[r];
            end
        end
    end

    // Flatten the eip array onto the output bus.
    always_comb begin
        o_eip = '0;
        for (int r = 0; r < NR_EIP; r++) begin
            o_eip[r*XLEN +: XLEN] = eip_q[r];
        end
    end

    assign o_fifo_cnt = cnt_q;
    assign o_drop_cnt = drop_q;
    assign o_busy     = pop;
endmodule

// File: tb/tb_imsic_msi_ingress.sv
// Bench for imsic_msi_ingress: directed scenarios, a queue-based reference model and a
// per-cycle compare process on the falling edge.
module tb_imsic_msi_ingress;
    localparam int NF = 7, XL = 64, NC = 2, FD = 4, NR = 4, MIW = 13, NREGS = 28;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [1:0]            hart_id;
    logic                  claim_vld;
    logic [2:0]            claim_file;
    logic [7:0]            claim_id;
    logic [NREGS-1:0]      sw_wr;
    logic [NREGS*XL-1:0]   sw_data;
    logic [NREGS*XL-1:0]   eip;
    logic [2:0]            fifo_cnt;
    logic [15:0]           drop_cnt;
    logic                  busy;

    imsic_msi_ingress_if #(.NR_CH(NC), .MIW(MIW)) msi_if ();

    imsic_msi_ingress dut (
        .clk          (clk),
        .rstn         (rstn),
        .hart_id      (hart_id),
        .msi          (msi_if),
        .i_claim_vld  (claim_vld),
        .i_claim_file (claim_file),
        .i_claim_id   (claim_id),
        .i_sw_wr      (sw_wr),
        .i_sw_data    (sw_data),
        .o_eip        (eip),
        .o_fifo_cnt   (fifo_cnt),
        .o_drop_cnt   (drop_cnt),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: FIFO as a queue of {file,id}, eip as plain words.
    logic [10:0] m_q [$];
    logic [63:0] m_eip [NREGS];
    int          m_rr   = 0;
    int          m_drop = 0;
    int          acc_log [$];

    task automatic model_reset();
        m_q.delete();
        acc_log.delete();
        m_rr   = 0;
        m_drop = 0;
        for (int r = 0; r < NREGS; r++) m_eip[r] = '0;
    endtask

    function automatic logic [1:0] exp_rdy();
        if (!rstn || m_q.size() >= FD) return 2'b00;
        for (int k = 0; k < NC; k++) begin
            int c = (m_rr + k) % NC;
            if (msi_if.i_msi_vld[c]) return 2'(1 << c);
        end
        return 2'b00;
    endfunction

    task automatic model_step();
        int          g = -1;
        int          pf, pid, h, f, id;
        bit          do_pop;
        logic [12:0] info;
        logic [63:0] n;
        if (m_q.size() < FD) begin
            for (int k = 0; k < NC; k++) begin
                int c = (m_rr + k) % NC;
                if (g < 0 && msi_if.i_msi_vld[c]) g = c;
            end
        end
        do_pop = (m_q.size() > 0);
        pf = 0;
        pid = 0;
        if (do_pop) begin
            pf  = int'(m_q[0][10:8]);
            pid = int'(m_q[0][7:0]);
            void'(m_q.pop_front());
        end
        for (int r = 0; r < NREGS; r++) begin
            n = sw_wr[r] ? sw_data[r*XL +: XL] : m_eip[r];
            if (claim_vld && claim_file < 3'(NF) && claim_id != 0 &&
                int'(claim_file) * NR + int'(claim_id) / XL == r)
                n[int'(claim_id) % XL] = 1'b0;
            if (do_pop && pf * NR + pid / XL == r) n[pid % XL] = 1'b1;
            m_eip[r] = n;
        end
        if (g >= 0) begin
            acc_log.push_back(g);
            m_rr = (g + 1) % NC;
            info = msi_if.i_msi_info[g*MIW +: MIW];
            h  = int'(info[12:11]);
            f  = int'(info[10:8]);
            id = int'(info[7:0]);
            if (h == int'(hart_id) && f < NF && id != 0) m_q.push_back(info[10:0]);
            else if (m_drop < 16'hFFFF) m_drop++;
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_reset();
        else model_step();
    end

    // Per-cycle comparison against the model, away from the rising edge.
    bit chk_en = 1'b0;
    int bad;
    always @(negedge clk) begin
        if (chk_en) begin
            bad = -1;
            for (int r = 0; r < NREGS; r++)
                if (bad < 0 && eip[r*XL +: XL] !== m_eip[r]) bad = r;
            n_total++;
            if (bad < 0) n_pass++;
            else $display("FAIL eip reg %0d: got %0h, expected %0h", bad, eip[bad*XL +: XL], m_eip[bad]);
            chk("fifo_cnt", 64'(fifo_cnt), 64'(m_q.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("busy", 64'(busy), 64'(m_q.size() != 0));
            chk("rdy", 64'(msi_if.o_msi_rdy), 64'(exp_rdy()));
            chk("rdy_full_gate", 64'(fifo_cnt == 3'd4 && msi_if.o_msi_rdy != 0), 64'(0));
            chk("cnt_bound", 64'(fifo_cnt <= 3'd4), 64'(1));
        end
    end

    function automatic logic [12:0] mk(input int h, input int f, input int id);
        return {2'(h), 3'(f), 8'(id)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic [12:0] info);
        msi_if.i_msi_vld[c] = v;
        msi_if.i_msi_info[c*MIW +: MIW] = info;
    endtask

    task automatic t_single(input string tag);
        set_ch(0, 1'b1, mk(1, 1, 70));
        #1 chk({tag, "_rdy"}, 64'(msi_if.o_msi_rdy), 64'h1);
        tick();
        chk({tag, "_cnt1"}, 64'(fifo_cnt), 64'd1);
        chk({tag, "_busy1"}, 64'(busy), 64'd1);
        set_ch(0, 1'b0, '0);
        tick();
        chk({tag, "_eip5"}, eip[5*XL +: XL], 64'h40);
        chk({tag, "_busy0"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        hart_id           = 2'd1;
        msi_if.i_msi_vld  = '0;
        msi_if.i_msi_info = '0;
        claim_vld         = 1'b0;
        claim_file        = '0;
        claim_id          = '0;
        sw_wr             = '0;
        sw_data           = '0;
        chk_en            = 1'b1;
        tick();
        chk("rst_rdy_low", 64'(msi_if.o_msi_rdy), 64'd0);
        tick();
        rstn = 1'b1;
        chk("rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_eip", 64'(eip == '0), 64'd1);

        // 1: single MSI
        t_single("single");

        // 2: fairness with both channels requesting
        do_reset();
        set_ch(0, 1'b1, mk(1, 0, 10));
        set_ch(1, 1'b1, mk(1, 2, 20));
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fair_rdy", 64'(msi_if.o_msi_rdy), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("fair_onehot", 64'($onehot(msi_if.o_msi_rdy)), 64'd1);
            tick();
        end
        set_ch(0, 1'b0, '0);
        set_ch(1, 1'b0, '0);
        chk("fair_log_len", 64'(acc_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            chk("fair_model_grant", 64'(acc_log[i]), 64'(i % 2));
        tick();
        tick();
        chk("fair_eip0", eip[0 +: XL], 64'h400);
        chk("fair_eip8", eip[8*XL +: XL], 64'h10_0000);

        // 3: five back-to-back accepts while popping
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 1'b1, mk(1, 3, 100 + i));
            #1 chk("bp_rdy", 64'(msi_if.o_msi_rdy), 64'h1);
            tick();
        end
        chk("bp_cnt", 64'(fifo_cnt), 64'd1);
        set_ch(0, 1'b0, '0);
        tick();
        tick();
        chk("bp_eip13", eip[13*XL +: XL], 64'h0000_01F0_0000_0000);

        // 4: filtering (id 256 does not fit the 8-bit id field and arrives as 0)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       set_ch(0, 1'b1, mk(2, 1, 5));
                1:       set_ch(0, 1'b1, mk(1, 1, 0));
                2:       set_ch(0, 1'b1, {2'd1, 3'd1, 8'h00});
                default: set_ch(0, 1'b1, mk(1, 7, 5));
            endcase
            #1 chk("filt_rdy", 64'(msi_if.o_msi_rdy), 64'h1);
            tick();
        end
        set_ch(0, 1'b0, '0);
        tick();
        chk("filt_drop", 64'(drop_cnt), 64'd4);
        chk("filt_eip_zero", 64'(eip == '0), 64'd1);
        chk("filt_cnt", 64'(fifo_cnt), 64'd0);

        // 5: same-cycle set, claim and software write on reg 0
        do_reset();
        set_ch(0, 1'b1, mk(1, 0, 5));
        tick();
        set_ch(0, 1'b0, '0);
        claim_vld = 1'b1;
        claim_file = 3'd0;
        claim_id = 8'd5;
        sw_wr[0] = 1'b1;
        sw_data[0 +: XL] = 64'hFF;
        tick();
        chk("merge_set_wins", eip[0 +: XL], 64'hFF);
        claim_id = 8'd3;
        tick();
        chk("merge_claim_sw", eip[0 +: XL], 64'hF7);
        sw_wr[0] = 1'b0;
        claim_id = 8'd5;
        tick();
        chk("merge_claim_only", eip[0 +: XL], 64'hD7);
        claim_id = 8'd0;
        tick();
        chk("merge_claim_id0", eip[0 +: XL], 64'hD7);
        claim_vld = 1'b0;
        sw_data = '0;

        // 6: reset in the middle of activity
        do_reset();
        set_ch(0, 1'b1, mk(3, 1, 5));
        tick();
        for (int i = 1; i <= 2; i++) begin
            set_ch(0, 1'b1, mk(1, 1, i));
            tick();
        end
        chk("mid_drop_before", 64'(drop_cnt), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_cnt", 64'(fifo_cnt), 64'd0);
        chk("mid_eip", 64'(eip == '0), 64'd1);
        chk("mid_drop", 64'(drop_cnt), 64'd0);
        chk("mid_rdy", 64'(msi_if.o_msi_rdy), 64'd0);
        set_ch(0, 1'b0, '0);
        tick();
        rstn = 1'b1;
        t_single("after_rst");

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
